// File: rtl/lsu_mem_port.sv
// Load/store unit: computes base+offset, rejects illegal/misaligned/out-of-range
// requests, strobes the cache port for one cycle and returns a response via valid/ready.
module lsu_mem_port #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write,
    output logic        mem_is_read,
    output logic        mem_is_write,
    output logic [2:0]  mem_mode,
    input  logic [31:0] mem_read
);

    localparam logic [31:0] MEM_BYTES_W = 32'(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t      state_q, state_d;
    logic        resp_fault_q, resp_fault_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_write_q, mem_write_d;
    logic [2:0]  mem_mode_q, mem_mode_d;
    logic        is_load_q, is_load_d;

    logic [31:0] addr;
    logic [2:0]  size;
    logic        load_f3_ok;
    logic        store_f3_ok;
    logic        fault;

    assign addr = req_base + req_offset;

    always_comb begin
        size        = 3'd0;
        load_f3_ok  = 1'b0;
        store_f3_ok = 1'b0;
        case (req_funct3)
            3'b000: begin size = 3'd1; load_f3_ok = 1'b1; store_f3_ok = 1'b1; end
            3'b001: begin size = 3'd2; load_f3_ok = 1'b1; store_f3_ok = 1'b1; end
            3'b010: begin size = 3'd4; load_f3_ok = 1'b1; store_f3_ok = 1'b1; end
            3'b100: begin size = 3'd1; load_f3_ok = 1'b1; end
            3'b101: begin size = 3'd2; load_f3_ok = 1'b1; end
            default: begin size = 3'd0; end
        endcase
    end

    // An illegal funct3 yields size 0, but that request already faults on the mode check.
    always_comb begin
        fault = 1'b0;
        if (req_is_load == req_is_store) fault = 1'b1;
        if (req_is_load && !load_f3_ok) fault = 1'b1;
        if (req_is_store && !store_f3_ok) fault = 1'b1;
        if (size == 3'd2 && addr[0] != 1'b0) fault = 1'b1;
        if (size == 3'd4 && addr[1:0] != 2'b00) fault = 1'b1;
        if (addr > (MEM_BYTES_W - {29'd0, size})) fault = 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        resp_fault_d  = resp_fault_q;
        resp_data_d   = resp_data_q;
        resp_rd_d     = resp_rd_q;
        mem_address_d = mem_address_q;
        mem_write_d   = mem_write_q;
        mem_mode_d    = mem_mode_q;
        is_load_d     = is_load_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    resp_rd_d   = req_rd;
                    resp_data_d = 32'd0;
                    if (fault) begin
                        resp_fault_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        resp_fault_d  = 1'b0;
                        mem_address_d = addr;
                        mem_write_d   = req_wdata;
                        mem_mode_d    = req_funct3;
                        is_load_d     = req_is_load;
                        state_d       = ACCESS;
                    end
                end
            end
            ACCESS: begin
                state_d = is_load_q ? CAPTURE : RESP;
            end
            // The cache registers its read data, so it is valid one cycle after the strobe.
            CAPTURE: begin
                resp_data_d = mem_read;
                state_d     = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            resp_fault_q  <= 1'b0;
            resp_data_q   <= 32'd0;
            resp_rd_q     <= 5'd0;
            mem_address_q <= 32'd0;
            mem_write_q   <= 32'd0;
            mem_mode_q    <= 3'd0;
            is_load_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            resp_fault_q  <= resp_fault_d;
            resp_data_q   <= resp_data_d;
            resp_rd_q     <= resp_rd_d;
            mem_address_q <= mem_address_d;
            mem_write_q   <= mem_write_d;
            mem_mode_q    <= mem_mode_d;
            is_load_q     <= is_load_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign resp_rd      = resp_rd_q;
    assign resp_data    = resp_data_q;
    assign resp_fault   = resp_fault_q;
    assign mem_address  = mem_address_q;
    assign mem_write    = mem_write_q;
    assign mem_mode     = mem_mode_q;
    // Gating with rst keeps a reset cycle from ever reaching the cache.
    assign mem_is_read  = (state_q == ACCESS) && is_load_q && !rst;
    assign mem_is_write = (state_q == ACCESS) && !is_load_q && !rst;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port with a big-endian byte-array cache model.
module tb_lsu_mem_port;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_load;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write;
    logic        mem_is_read;
    logic        mem_is_write;
    logic [2:0]  mem_mode;
    logic [31:0] mem_read;

    lsu_mem_port #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rd(resp_rd), .resp_data(resp_data), .resp_fault(resp_fault),
        .mem_address(mem_address), .mem_write(mem_write),
        .mem_is_read(mem_is_read), .mem_is_write(mem_is_write),
        .mem_mode(mem_mode), .mem_read(mem_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Cache model: registered read, big-endian byte order, mode-driven extension.
    logic [7:0] arr [0:1023];
    always @(posedge clk) begin
        if (mem_is_write) begin
            case (mem_mode[1:0])
                2'b00: arr[mem_address[9:0]] <= mem_write[7:0];
                2'b01: begin
                    arr[mem_address[9:0]]         <= mem_write[15:8];
                    arr[mem_address[9:0] + 10'd1] <= mem_write[7:0];
                end
                default: begin
                    arr[mem_address[9:0]]         <= mem_write[31:24];
                    arr[mem_address[9:0] + 10'd1] <= mem_write[23:16];
                    arr[mem_address[9:0] + 10'd2] <= mem_write[15:8];
                    arr[mem_address[9:0] + 10'd3] <= mem_write[7:0];
                end
            endcase
        end
        if (mem_is_read) begin
            case (mem_mode)
                3'b000: mem_read <= {{24{arr[mem_address[9:0]][7]}}, arr[mem_address[9:0]]};
                3'b100: mem_read <= {24'd0, arr[mem_address[9:0]]};
                3'b001: mem_read <= {{16{arr[mem_address[9:0]][7]}}, arr[mem_address[9:0]],
                                     arr[mem_address[9:0] + 10'd1]};
                3'b101: mem_read <= {16'd0, arr[mem_address[9:0]], arr[mem_address[9:0] + 10'd1]};
                default: mem_read <= {arr[mem_address[9:0]], arr[mem_address[9:0] + 10'd1],
                                      arr[mem_address[9:0] + 10'd2], arr[mem_address[9:0] + 10'd3]};
            endcase
        end
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        fault;
        int          acc;
        int          lat;
        int          wr;
        int          rdn;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts strobes per transaction and checks each response at its handshake.
    int  wr_cnt = 0;
    int  rd_cnt = 0;
    bit  seen = 0;
    int  first_cyc = 0;
    always @(negedge clk) begin
        if (rst) begin
            wr_cnt = 0;
            rd_cnt = 0;
            seen   = 0;
        end else begin
            wr_cnt += int'(mem_is_write);
            rd_cnt += int'(mem_is_read);
            if (resp_valid && !seen) begin
                seen      = 1;
                first_cyc = cyc;
            end
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_rd", 32'(resp_rd), 32'(e.rd));
                    chk("resp_data", resp_data, e.data);
                    chk("resp_fault", 32'(resp_fault), 32'(e.fault));
                    chk("latency", 32'(first_cyc - e.acc), 32'(e.lat));
                    chk("write_strobes", 32'(wr_cnt), 32'(e.wr));
                    chk("read_strobes", 32'(rd_cnt), 32'(e.rdn));
                end
                wr_cnt = 0;
                rd_cnt = 0;
                seen   = 0;
            end
        end
    end

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] exp_d, input logic exp_f,
                         input bit push, output int acc_o);
        int   n;
        exp_t e;
        n = 0;
        acc_o = -1;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_is_load  = ld;
        req_is_store = st;
        req_funct3   = f3;
        req_base     = base;
        req_offset   = off;
        req_wdata    = wd;
        req_rd       = rd;
        req_valid    = 1'b1;
        acc_o        = cyc;
        if (push) begin
            e.rd    = rd;
            e.data  = exp_d;
            e.fault = exp_f;
            e.acc   = cyc;
            e.lat   = exp_f ? 1 : (ld ? 3 : 2);
            e.wr    = (!exp_f && st) ? 1 : 0;
            e.rdn   = (!exp_f && ld) ? 1 : 0;
            q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_req_ready"},    32'(req_ready), 32'd1);
        chk({p, "_resp_valid"},   32'(resp_valid), 32'd0);
        chk({p, "_resp_fault"},   32'(resp_fault), 32'd0);
        chk({p, "_resp_data"},    resp_data, 32'd0);
        chk({p, "_resp_rd"},      32'(resp_rd), 32'd0);
        chk({p, "_mem_address"},  mem_address, 32'd0);
        chk({p, "_mem_write"},    mem_write, 32'd0);
        chk({p, "_mem_mode"},     32'(mem_mode), 32'd0);
        chk({p, "_mem_is_read"},  32'(mem_is_read), 32'd0);
        chk({p, "_mem_is_write"}, 32'(mem_is_write), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int cr;
        int n;
        for (int i = 0; i < 1024; i++) arr[i] = 8'h00;
        arr[16] = 8'hDE; arr[17] = 8'hAD; arr[18] = 8'hBE; arr[19] = 8'hEF;
        arr[48] = 8'hCA; arr[49] = 8'hFE; arr[50] = 8'hF0; arr[51] = 8'h0D;
        arr[1020] = 8'h01; arr[1021] = 8'h02; arr[1022] = 8'h03; arr[1023] = 8'h04;
        mem_read     = 32'd0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_is_load  = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'd0;
        req_base     = 32'd0;
        req_offset   = 32'd0;
        req_wdata    = 32'd0;
        req_rd       = 5'd0;
        resp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst = 1'b0;
        @(posedge clk); #1;

        // Loads from preloaded bytes
        issue(1, 0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd1, 32'hDEADBEEF, 0, 1, acc);
        issue(1, 0, 3'b000, 32'h14, 32'hFFFFFFFC, 32'h0, 5'd2, 32'hFFFFFFDE, 0, 1, acc);
        issue(1, 0, 3'b101, 32'h12, 32'h0, 32'h0, 5'd3, 32'h0000BEEF, 0, 1, acc);

        // Store then load back
        issue(0, 1, 3'b010, 32'h20, 32'h0, 32'h12345678, 5'd4, 32'h0, 0, 1, acc);
        issue(1, 0, 3'b010, 32'h20, 32'h0, 32'h0, 5'd5, 32'h12345678, 0, 1, acc);
        issue(0, 1, 3'b000, 32'h21, 32'h0, 32'h000000AB, 5'd6, 32'h0, 0, 1, acc);
        issue(1, 0, 3'b010, 32'h20, 32'h0, 32'h0, 5'd7, 32'h12AB5678, 0, 1, acc);

        // Fault and boundary cases
        issue(1, 0, 3'b001, 32'h11, 32'h0, 32'h0, 5'd8, 32'h0, 1, 1, acc);
        issue(1, 0, 3'b010, 32'h3FE, 32'h0, 32'h0, 5'd11, 32'h0, 1, 1, acc);
        issue(1, 0, 3'b010, 32'h3FC, 32'h0, 32'h0, 5'd12, 32'h01020304, 0, 1, acc);
        issue(1, 0, 3'b011, 32'h10, 32'h0, 32'h0, 5'd13, 32'h0, 1, 1, acc);
        issue(1, 1, 3'b010, 32'h10, 32'h0, 32'h0, 5'd14, 32'h0, 1, 1, acc);
        issue(0, 1, 3'b100, 32'h10, 32'h0, 32'h55, 5'd15, 32'h0, 1, 1, acc);
        issue(0, 0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd16, 32'h0, 1, 1, acc);
        drain();

        // Backpressure on a load response, then back-to-back accept
        resp_ready = 1'b0;
        issue(1, 0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd9, 32'hDEADBEEF, 0, 1, acc);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_resp_valid", 32'(resp_valid), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_data", resp_data, 32'hDEADBEEF);
            chk("bp_hold_rd", 32'(resp_rd), 32'd9);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        cr = cyc;
        issue(1, 0, 3'b101, 32'h10, 32'h0, 32'h0, 5'd10, 32'h0000DEAD, 0, 1, acc);
        chk("b2b_accept_cycle", 32'(acc), 32'(cr + 1));
        drain();

        // Address wraps modulo 2^32
        issue(1, 0, 3'b010, 32'hFFFFFFFC, 32'h14, 32'h0, 5'd17, 32'hDEADBEEF, 0, 1, acc);
        drain();

        // Reset while a store is in ACCESS
        issue(0, 1, 3'b010, 32'h30, 32'h0, 32'hFFFFFFFF, 5'd18, 32'h0, 0, 0, acc);
        chk("rst_pre_wr_strobe", 32'(mem_is_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_access_wr_strobe", 32'(mem_is_write), 32'd0);
        @(posedge clk); #1;
        check_reset_vals("rst_access");
        rst = 1'b0;
        @(posedge clk); #1;
        issue(1, 0, 3'b010, 32'h30, 32'h0, 32'h0, 5'd19, 32'hCAFEF00D, 0, 1, acc);
        drain();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit between the execute stage and the byte-addressed data cache.
- Accepts one memory request at a time and computes the effective address as base + offset.
- Checks the request for an illegal funct3, misalignment and out-of-range addresses, then drives the cache's single read/write port for exactly one cycle.
- Returns load data, a store acknowledge or a fault to writeback through a valid/ready handshake.

Parameters:
- MEM_BYTES, 1024, size of cache byte array; legal byte addresses are 0..MEM_BYTES-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request offered by execute.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_is_load  in  1  request is a load.
- req_is_store  in  1  request is a store.
- req_funct3  in  3  access mode: B=000, H=001, W=010, BU=100, HU=101.
- req_base  in  32  rs1 value.
- req_offset  in  32  sign-extended immediate.
- req_wdata  in  32  store data; low bytes are used.
- req_rd  in  5  destination register tag.
- resp_valid  out  1  response available.
- resp_ready  in  1  writeback accepts the response.
- resp_rd  out  5  tag echoed from the request.
- resp_data  out  32  load result; 0 for stores and faults.
- resp_fault  out  1  request was rejected; no cache access was made.
- mem_address  out  32  cache address.
- mem_write  out  32  cache write data.
- mem_is_read  out  1  cache read strobe.
- mem_is_write  out  1  cache write strobe.
- mem_mode  out  3  cache mode; equals funct3.
- mem_read  in  32  cache read data; registered in the cache and valid the cycle after the strobe.

Behaviour:
- States: IDLE, ACCESS, CAPTURE, RESP.
- Reset state is IDLE. Reset values: req_ready=1; resp_valid=0; resp_fault=0; resp_data=0; resp_rd=0; mem_address=0; mem_write=0; mem_mode=0; mem_is_read=0; mem_is_write=0.
- Accept: occurs when req_valid && req_ready at a posedge.
  - addr = req_base + req_offset, modulo 2^32; overflow is ignored.
  - Request size: 1 byte for B/BU, 2 for H/HU, 4 for W.
- Fault conditions, any one of:
  - req_is_load == req_is_store.
  - Load with funct3 not in {000,001,010,100,101}.
  - Store with funct3 not in {000,001,010}.
  - Size 2 with addr[0]!=0.
  - Size 4 with addr[1:0]!=0.
  - addr > MEM_BYTES - size, compared as unsigned 32-bit values.
- On fault: go directly to RESP with resp_fault=1, resp_data=0. The mem strobes never assert. Accept-to-resp_valid latency is 1 cycle.
- No fault: latch addr, wdata, funct3, rd and load/store into the mem_* registers, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_is_read = load, mem_is_write = store.
  - Both strobes are combinationally ANDed with !rst, so no cache write happens in a reset cycle.
  - Load: next state is CAPTURE. Store: next state is RESP.
- CAPTURE (1 cycle): register mem_read into resp_data, then go to RESP. Load latency accept-to-resp_valid is 3 cycles; store latency is 2.
- RESP:
  - resp_valid=1; resp_data, resp_rd and resp_fault are held stable while resp_ready=0.
  - On resp_ready: go to IDLE and clear resp_valid.
  - A new request can be accepted no earlier than the cycle after the handshake.
- Strobe hygiene: mem_is_read/mem_is_write are 0 in every state except ACCESS. mem_address, mem_write and mem_mode hold their last values.
- Data conventions: the unit performs no sign or zero extension; the cache applies mode and big-endian byte order (lowest address is MSB). Store data is passed through unmodified.
- rst in any state: IDLE at the next edge, all outputs return to their reset values, and any in-flight response is discarded.

Test Plan:
- Loads: preload bytes 0x10..0x13 = DE AD BE EF.
  - LW base=0x10, off=0: resp_valid 3 cycles after accept, resp_data=0xDEADBEEF, resp_fault=0.
  - LB base=0x14, off=-4: 0xFFFFFFDE.
  - HU at 0x12: 0x0000BEEF.
- Store/load: SW 0x12345678 at 0x20, then LW 0x20 → 0x12345678. SB 0xAB at 0x21, then LW 0x20 → 0x12AB5678. mem_is_write is high for exactly 1 cycle per store.
- Faults:
  - LH at 0x11 → fault.
  - LW at 0x3FE → fault.
  - LW at 0x3FC → no fault.
  - Load with funct3=011 → fault.
  - req_is_load=req_is_store=1 → fault.
  - In every fault case: 1-cycle latency, mem strobes never asserted.
- Backpressure: hold resp_ready=0 for 5 cycles after a load. resp_valid and resp_data stay stable and req_ready stays 0. Raise resp_ready: IDLE next cycle, and a back-to-back request is accepted the following cycle.
- Reset in ACCESS of SW 0xFFFFFFFF at 0x30: mem_is_write stays 0, a later LW 0x30 returns the preloaded value, and all outputs equal their reset values one cycle later.
- Address wrap: base=0xFFFFFFFC, off=0x14 → addr 0x10, LW → 0xDEADBEEF.
